// File: rtl/mc_control_fsm_if.sv
// Memory-side handshake between the multicycle control unit and the memory/store-align path.
interface mc_control_fsm_if;
    logic       mem_req;
    logic       mem_ready;
    logic       adr_src;
    logic [3:0] mem_write;
    logic [3:0] mem_byte_mask;

    modport master (
        output mem_req,
        output adr_src,
        output mem_write,
        input  mem_ready,
        input  mem_byte_mask
    );

    modport slave (
        input  mem_req,
        input  adr_src,
        input  mem_write,
        output mem_ready,
        output mem_byte_mask
    );
endinterface

// File: rtl/mc_control_fsm.sv
// RV32I multicycle control unit: wait-state memory handshake, bus watchdog,
// sticky trap state and retired-instruction counter.
module mc_control_fsm #(
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned RETIRE_W = 32,
    parameter bit          TRAP_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    mc_control_fsm_if.master    bus,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                zero_flag,
    input  logic [31:0]         alu_result,
    input  logic                trap_ack,
    output logic                ir_write,
    output logic                reg_write,
    output logic                pc_update,
    output logic [1:0]          pc_src,
    output logic                branch,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          result_src,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic                retire,
    output logic [RETIRE_W-1:0] retire_count,
    output logic [4:0]          fsm_state
);

    localparam logic [4:0] StFetch    = 5'd0;
    localparam logic [4:0] StDecode   = 5'd1;
    localparam logic [4:0] StExecR    = 5'd2;
    localparam logic [4:0] StJal      = 5'd3;
    localparam logic [4:0] StExecI    = 5'd4;
    localparam logic [4:0] StMemAdr   = 5'd5;
    localparam logic [4:0] StAluWb    = 5'd6;
    localparam logic [4:0] StMemWrite = 5'd7;
    localparam logic [4:0] StMemRead  = 5'd8;
    localparam logic [4:0] StMemWb    = 5'd9;
    localparam logic [4:0] StBranch   = 5'd10;
    localparam logic [4:0] StLui      = 5'd11;
    localparam logic [4:0] StAuipc    = 5'd12;
    localparam logic [4:0] StJalrCalc = 5'd13;
    localparam logic [4:0] StJalrLink = 5'd14;
    localparam logic [4:0] StTrap     = 5'd15;

    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpSType  = 7'b0100011;
    localparam logic [6:0] OpBType  = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpFence  = 7'b0001111;

    localparam logic       AdrPc       = 1'b0;
    localparam logic       AdrResult   = 1'b1;
    localparam logic [1:0] PcIncrement = 2'd0;
    localparam logic [1:0] PcJump      = 2'd1;
    localparam logic [1:0] PcAluResult = 2'd2;
    localparam logic [1:0] SrcAOldPc   = 2'd0;
    localparam logic [1:0] SrcARd1     = 2'd1;
    localparam logic [1:0] SrcAZero    = 2'd2;
    localparam logic [1:0] SrcBImmExt  = 2'd0;
    localparam logic [1:0] SrcBRd2     = 2'd1;
    localparam logic [1:0] SrcBFour    = 2'd2;
    localparam logic [1:0] ResAluOut   = 2'd0;
    localparam logic [1:0] ResData     = 2'd1;

    localparam logic [1:0] CauseNone    = 2'd0;
    localparam logic [1:0] CauseOpcode  = 2'd1;
    localparam logic [1:0] CauseFunct3  = 2'd2;
    localparam logic [1:0] CauseTimeout = 2'd3;

    localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [4:0]          state_q, state_d;
    logic [1:0]          cause_q, cause_d;
    logic [WdW-1:0]      wd_q, wd_d;
    logic [RETIRE_W-1:0] count_q;

    logic       mem_req_s;
    logic       adr_src_s;
    logic [3:0] mem_write_s;
    logic       in_wait;
    logic       ill;
    logic [1:0] ill_cause;
    logic       taken;
    logic       wd_expire;

    // mem_ready on the final watchdog cycle still completes the access.
    assign wd_expire = (TIMEOUT != 0) && (wd_q == WdW'(TIMEOUT - 1)) && !bus.mem_ready;

    always_comb begin
        if (funct3[2]) begin
            taken = (alu_result == 32'd1);
        end else if (funct3[0]) begin
            taken = !zero_flag;
        end else begin
            taken = zero_flag;
        end
    end

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        wd_d        = '0;
        mem_req_s   = 1'b0;
        adr_src_s   = AdrPc;
        mem_write_s = 4'b0000;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        pc_update   = 1'b0;
        pc_src      = PcIncrement;
        branch      = 1'b0;
        alu_src_a   = SrcAOldPc;
        alu_src_b   = SrcBImmExt;
        result_src  = ResAluOut;
        trap        = 1'b0;
        retire      = 1'b0;
        in_wait     = 1'b0;
        ill         = 1'b0;
        ill_cause   = CauseNone;

        case (state_q)
            StFetch: begin
                mem_req_s = 1'b1;
                in_wait   = 1'b1;
                if (bus.mem_ready) begin
                    ir_write  = 1'b1;
                    pc_update = 1'b1;
                    state_d   = StDecode;
                end
            end
            StDecode: begin
                case (opcode)
                    OpJal:           state_d = StJal;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpLoad, OpSType: state_d = StMemAdr;
                    OpLui:           state_d = StLui;
                    OpAuipc:         state_d = StAuipc;
                    OpJalr:          state_d = StJalrCalc;
                    OpBType: begin
                        if (funct3[2:1] == 2'b01) begin
                            ill       = 1'b1;
                            ill_cause = CauseFunct3;
                        end else begin
                            state_d = StBranch;
                        end
                    end
                    OpFence: begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    default: begin
                        ill       = 1'b1;
                        ill_cause = CauseOpcode;
                    end
                endcase
            end
            StExecR: begin
                alu_src_a = SrcARd1;
                alu_src_b = SrcBRd2;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = SrcARd1;
                state_d   = StAluWb;
            end
            StMemAdr: begin
                alu_src_a = SrcARd1;
                state_d   = (opcode == OpSType) ? StMemWrite : StMemRead;
            end
            StLui: begin
                alu_src_a = SrcAZero;
                state_d   = StAluWb;
            end
            StAuipc: state_d = StAluWb;
            StJal: begin
                alu_src_b = SrcBFour;
                pc_src    = PcJump;
                pc_update = 1'b1;
                state_d   = StAluWb;
            end
            StJalrCalc: begin
                alu_src_a = SrcARd1;
                state_d   = StJalrLink;
            end
            StJalrLink: begin
                alu_src_b = SrcBFour;
                pc_src    = PcAluResult;
                pc_update = 1'b1;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StMemRead: begin
                mem_req_s = 1'b1;
                adr_src_s = AdrResult;
                in_wait   = 1'b1;
                if (bus.mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                result_src = ResData;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                mem_req_s   = 1'b1;
                adr_src_s   = AdrResult;
                mem_write_s = bus.mem_byte_mask;
                in_wait     = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StBranch: begin
                alu_src_a = SrcARd1;
                alu_src_b = SrcBRd2;
                branch    = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
                if (taken) begin
                    pc_src    = PcJump;
                    pc_update = 1'b1;
                end
            end
            StTrap: begin
                trap = 1'b1;
                if (trap_ack) begin
                    state_d = StFetch;
                    cause_d = CauseNone;
                end
            end
            default: state_d = StFetch;
        endcase

        if (ill) begin
            if (TRAP_EN) begin
                state_d = StTrap;
                cause_d = ill_cause;
            end else begin
                retire  = 1'b1;
                state_d = StFetch;
            end
        end

        if (in_wait && !bus.mem_ready) begin
            if (wd_expire) begin
                state_d = StTrap;
                cause_d = CauseTimeout;
            end else begin
                wd_d = wd_q + WdW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            cause_q <= CauseNone;
            wd_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            wd_q    <= wd_d;
            if (retire) count_q <= count_q + RETIRE_W'(1);
        end
    end

    // Reset resolves to FETCH, which would otherwise request memory during reset.
    assign bus.mem_req   = mem_req_s && !reset;
    assign bus.adr_src   = adr_src_s;
    assign bus.mem_write = mem_write_s;
    assign trap_cause    = cause_q;
    assign retire_count  = count_q;
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench: an instruction-level model emits the expected per-cycle outputs,
// one compare process checks them, literal probes pin selected values.
module tb_mc_control_fsm;

    localparam int unsigned TO = 4;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    localparam logic [1:0] A_OLDPC = 2'd0, A_RD1 = 2'd1, A_ZERO = 2'd2;
    localparam logic [1:0] B_IMM = 2'd0, B_RD2 = 2'd1, B_FOUR = 2'd2;
    localparam logic [1:0] PC_JUMP = 2'd1, PC_ALU = 2'd2;
    localparam logic [1:0] RES_DATA = 2'd1;

    typedef struct packed {
        logic [4:0] state;
        logic       mem_req;
        logic       adr_src;
        logic       ir_write;
        logic       reg_write;
        logic       pc_update;
        logic [1:0] pc_src;
        logic [3:0] mem_write;
        logic       branch;
        logic [1:0] alu_a;
        logic [1:0] alu_b;
        logic [1:0] result_src;
        logic       trap;
        logic [1:0] cause;
        logic       retire;
        logic [3:0] count;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, reset_b;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        zero_flag;
    logic [31:0] alu_result;
    logic [3:0]  mem_byte_mask;
    logic        mem_ready;
    logic        trap_ack;

    mc_control_fsm_if bus_a ();
    mc_control_fsm_if bus_b ();
    assign bus_a.mem_ready     = mem_ready;
    assign bus_a.mem_byte_mask = mem_byte_mask;
    assign bus_b.mem_ready     = mem_ready;
    assign bus_b.mem_byte_mask = mem_byte_mask;

    logic       ir_a, rw_a, pcu_a, br_a, tr_a, ret_a;
    logic [1:0] pcs_a, aa_a, ab_a, rs_a, tc_a;
    logic [3:0] rc_a;
    logic [4:0] st_a;
    logic       ir_b, rw_b, pcu_b, br_b, tr_b, ret_b;
    logic [1:0] pcs_b, aa_b, ab_b, rs_b, tc_b;
    logic [3:0] rc_b;
    logic [4:0] st_b;

    mc_control_fsm #(.TIMEOUT(TO), .RETIRE_W(4), .TRAP_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset_a), .bus(bus_a), .opcode(opcode), .funct3(funct3),
        .zero_flag(zero_flag), .alu_result(alu_result), .trap_ack(trap_ack),
        .ir_write(ir_a), .reg_write(rw_a), .pc_update(pcu_a), .pc_src(pcs_a), .branch(br_a),
        .alu_src_a(aa_a), .alu_src_b(ab_a), .result_src(rs_a), .trap(tr_a), .trap_cause(tc_a),
        .retire(ret_a), .retire_count(rc_a), .fsm_state(st_a)
    );

    mc_control_fsm #(.TIMEOUT(TO), .RETIRE_W(4), .TRAP_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset_b), .bus(bus_b), .opcode(opcode), .funct3(funct3),
        .zero_flag(zero_flag), .alu_result(alu_result), .trap_ack(trap_ack),
        .ir_write(ir_b), .reg_write(rw_b), .pc_update(pcu_b), .pc_src(pcs_b), .branch(br_b),
        .alu_src_a(aa_b), .alu_src_b(ab_b), .result_src(rs_b), .trap(tr_b), .trap_cause(tc_b),
        .retire(ret_b), .retire_count(rc_b), .fsm_state(st_b)
    );

    obs_t obs_a, obs_b;
    assign obs_a = {st_a, bus_a.mem_req, bus_a.adr_src, ir_a, rw_a, pcu_a, pcs_a,
                    bus_a.mem_write, br_a, aa_a, ab_a, rs_a, tr_a, tc_a, ret_a, rc_a};
    assign obs_b = {st_b, bus_b.mem_req, bus_b.adr_src, ir_b, rw_b, pcu_b, pcs_b,
                    bus_b.mem_write, br_b, aa_b, ab_b, rs_b, tr_b, tc_b, ret_b, rc_b};

    int   n_checks = 0;
    int   n_errors = 0;
    obs_t exp_o;
    logic exp_valid = 1'b0;
    logic sel = 1'b0;
    logic lit_req = 1'b0;
    int   lit_code, lit_val;
    int   lit_step = -1;
    int   lit_pend_code, lit_pend_val;
    logic [3:0] m_count;
    logic [1:0] m_cause;
    int   ncyc, last_cycles;
    obs_t act;
    int   lit_act;

    function automatic string lit_name(input int c);
        case (c)
            0:       return "retire_count";
            1:       return "trap_cause";
            2:       return "mem_write";
            3:       return "pc_update";
            4:       return "fsm_state";
            default: return "instr_cycles";
        endcase
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            act = sel ? obs_b : obs_a;
            n_checks++;
            if (act !== exp_o) begin
                n_errors++;
                $display("FAIL outputs state=%0d got=%h want=%h", exp_o.state, act, exp_o);
            end
            if (lit_req) begin
                case (lit_code)
                    0:       lit_act = int'(act.count);
                    1:       lit_act = int'(act.cause);
                    2:       lit_act = int'(act.mem_write);
                    3:       lit_act = int'(act.pc_update);
                    4:       lit_act = int'(act.state);
                    default: lit_act = last_cycles;
                endcase
                n_checks++;
                if (lit_act != lit_val) begin
                    n_errors++;
                    $display("FAIL %s got=%0d want=%0d", lit_name(lit_code), lit_act, lit_val);
                end
            end
        end
    end

    function automatic obs_t base(input logic [4:0] st);
        obs_t o;
        o       = '0;
        o.state = st;
        o.cause = m_cause;
        o.count = m_count;
        return o;
    endfunction

    function automatic obs_t mk(input logic [4:0] st, input logic [1:0] a, input logic [1:0] b);
        obs_t o;
        o       = base(st);
        o.alu_a = a;
        o.alu_b = b;
        return o;
    endfunction

    task automatic lit(input int code, input int val, input int at);
        lit_pend_code = code;
        lit_pend_val  = val;
        lit_step      = at;
    endtask

    task automatic step(input obs_t e, input logic rdy);
        mem_ready = rdy;
        exp_o     = e;
        exp_valid = 1'b1;
        if (lit_step == ncyc) begin
            lit_req  = 1'b1;
            lit_code = lit_pend_code;
            lit_val  = lit_pend_val;
            lit_step = -1;
        end
        @(posedge clk);
        #1;
        lit_req = 1'b0;
        if (e.retire) m_count = m_count + 4'd1;
        ncyc++;
    endtask

    task automatic set_rst(input logic v);
        if (sel) reset_b = v;
        else     reset_a = v;
    endtask

    task automatic trap_seq(input logic [1:0] c);
        obs_t e;
        m_cause = c;
        for (int i = 0; i < 3; i++) begin
            e        = base(5'd15);
            e.trap   = 1'b1;
            trap_ack = (i == 2);
            step(e, 1'b0);
        end
        trap_ack = 1'b0;
        m_cause  = 2'd0;
    endtask

    // Access completes after nwait not-ready cycles unless the watchdog fires first.
    task automatic wait_phase(input obs_t tmpl, input int nwait, output bit timed_out);
        obs_t e;
        timed_out = 1'b0;
        for (int i = 0; i <= nwait; i++) begin
            e       = tmpl;
            e.count = m_count;
            if (i != nwait) begin
                e.ir_write  = 1'b0;
                e.pc_update = 1'b0;
                e.retire    = 1'b0;
            end
            if (i == int'(TO) - 1 && i != nwait) begin
                step(e, 1'b0);
                trap_seq(2'd3);
                timed_out = 1'b1;
                return;
            end
            step(e, i == nwait);
        end
    endtask

    task automatic alu_wb();
        obs_t e;
        e           = base(5'd6);
        e.reg_write = 1'b1;
        e.retire    = 1'b1;
        step(e, 1'b1);
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input int fw, input int mw,
                         input logic z, input logic [31:0] alu, input logic [3:0] mask);
        obs_t e;
        bit   to;
        logic [1:0] ill;
        last_cycles   = ncyc;
        ncyc          = 0;
        opcode        = op;
        funct3        = f3;
        zero_flag     = z;
        alu_result    = alu;
        mem_byte_mask = mask;

        e           = base(5'd0);
        e.mem_req   = 1'b1;
        e.ir_write  = 1'b1;
        e.pc_update = 1'b1;
        wait_phase(e, fw, to);
        if (to) return;

        ill = 2'd0;
        case (op)
            OP_B: if (f3 == 3'b010 || f3 == 3'b011) ill = 2'd2;
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE: ;
            default: ill = 2'd1;
        endcase

        e = base(5'd1);
        if (op == OP_FENCE || (ill != 2'd0 && sel)) e.retire = 1'b1;
        step(e, 1'b1);
        if (ill != 2'd0) begin
            if (!sel) trap_seq(ill);
            return;
        end

        case (op)
            OP_R:     begin step(mk(5'd2, A_RD1, B_RD2), 1'b1); alu_wb(); end
            OP_I:     begin step(mk(5'd4, A_RD1, B_IMM), 1'b1); alu_wb(); end
            OP_LUI:   begin step(mk(5'd11, A_ZERO, B_IMM), 1'b1); alu_wb(); end
            OP_AUIPC: begin step(mk(5'd12, A_OLDPC, B_IMM), 1'b1); alu_wb(); end
            OP_JAL: begin
                e           = mk(5'd3, A_OLDPC, B_FOUR);
                e.pc_src    = PC_JUMP;
                e.pc_update = 1'b1;
                step(e, 1'b1);
                alu_wb();
            end
            OP_JALR: begin
                step(mk(5'd13, A_RD1, B_IMM), 1'b1);
                e           = mk(5'd14, A_OLDPC, B_FOUR);
                e.pc_src    = PC_ALU;
                e.pc_update = 1'b1;
                step(e, 1'b1);
                alu_wb();
            end
            OP_LOAD: begin
                step(mk(5'd5, A_RD1, B_IMM), 1'b1);
                e         = base(5'd8);
                e.mem_req = 1'b1;
                e.adr_src = 1'b1;
                wait_phase(e, mw, to);
                if (to) return;
                e            = base(5'd9);
                e.result_src = RES_DATA;
                e.reg_write  = 1'b1;
                e.retire     = 1'b1;
                step(e, 1'b1);
            end
            OP_STORE: begin
                step(mk(5'd5, A_RD1, B_IMM), 1'b1);
                e           = base(5'd7);
                e.mem_req   = 1'b1;
                e.adr_src   = 1'b1;
                e.mem_write = mask;
                e.retire    = 1'b1;
                wait_phase(e, mw, to);
            end
            OP_B: begin
                e        = mk(5'd10, A_RD1, B_RD2);
                e.branch = 1'b1;
                e.retire = 1'b1;
                if ((f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : (alu == 32'd1)) begin
                    e.pc_src    = PC_JUMP;
                    e.pc_update = 1'b1;
                end
                step(e, 1'b1);
            end
            default: ;
        endcase
    endtask

    task automatic mid_reset();
        obs_t e;
        last_cycles = ncyc;
        ncyc        = 0;
        opcode      = OP_I;
        e           = base(5'd0);
        e.mem_req   = 1'b1;
        step(e, 1'b0);
        set_rst(1'b1);
        m_count = 4'd0;
        m_cause = 2'd0;
        step(base(5'd0), 1'b0);
        set_rst(1'b0);
    endtask

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        opcode = '0; funct3 = '0; zero_flag = 1'b0; alu_result = '0;
        mem_byte_mask = '0; mem_ready = 1'b0; trap_ack = 1'b0;
        m_count = 4'd0; m_cause = 2'd0; ncyc = 0; last_cycles = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_a = 1'b0;

        lit(4, 0, 0);  instr(OP_I, 3'b000, 0, 0, 1'b0, 32'd0, 4'b0000);      // addi
        lit(0, 1, 0);  instr(OP_LOAD, 3'b010, 3, 1, 1'b0, 32'd0, 4'b0000);   // lw
        lit(5, 9, 0);  instr(OP_FENCE, 3'b000, 0, 0, 1'b0, 32'd0, 4'b0000);
        lit(2, 3, 3);  instr(OP_STORE, 3'b001, 0, 1, 1'b0, 32'd0, 4'b0011);  // sw
        lit(1, 3, 4);  instr(OP_I, 3'b000, 10, 0, 1'b0, 32'd0, 4'b0000);     // fetch timeout
        instr(OP_I, 3'b000, 3, 0, 1'b0, 32'd0, 4'b0000);                     // ready just in time
        instr(OP_LOAD, 3'b010, 0, 6, 1'b0, 32'd0, 4'b0000);                  // memread timeout
        instr(OP_STORE, 3'b010, 0, 8, 1'b0, 32'd0, 4'b1111);                 // memwrite timeout
        lit(1, 1, 2);  instr(OP_BAD, 3'b000, 0, 0, 1'b0, 32'd0, 4'b0000);
        lit(1, 2, 2);  instr(OP_B, 3'b010, 0, 0, 1'b0, 32'd0, 4'b0000);
        lit(3, 1, 2);  instr(OP_B, 3'b100, 0, 0, 1'b0, 32'd1, 4'b0000);      // blt taken
        lit(3, 0, 2);  instr(OP_B, 3'b001, 0, 0, 1'b1, 32'd0, 4'b0000);      // bne not taken
        instr(OP_B, 3'b000, 1, 0, 1'b1, 32'd0, 4'b0000);                     // beq taken
        instr(OP_B, 3'b101, 0, 0, 1'b0, 32'd0, 4'b0000);                     // bge not taken
        instr(OP_R, 3'b000, 0, 0, 1'b0, 32'd0, 4'b0000);
        instr(OP_JAL, 3'b000, 2, 0, 1'b0, 32'd0, 4'b0000);
        instr(OP_JALR, 3'b000, 0, 0, 1'b0, 32'd0, 4'b0000);
        instr(OP_LUI, 3'b000, 0, 0, 1'b0, 32'd0, 4'b0000);
        instr(OP_AUIPC, 3'b000, 0, 0, 1'b0, 32'd0, 4'b0000);

        mid_reset();
        for (int i = 0; i < 15; i++) instr(OP_FENCE, 3'b000, 0, 0, 1'b0, 32'd0, 4'b0000);
        lit(0, 15, 0); instr(OP_FENCE, 3'b000, 0, 0, 1'b0, 32'd0, 4'b0000);
        lit(0, 0, 0);  instr(OP_I, 3'b000, 0, 0, 1'b0, 32'd0, 4'b0000);

        // Hand over to the TRAP_EN=0 instance.
        reset_a = 1'b1;
        sel     = 1'b1;
        reset_b = 1'b0;
        m_count = 4'd0;
        m_cause = 2'd0;
        lit(4, 0, 0);  instr(OP_BAD, 3'b000, 0, 0, 1'b0, 32'd0, 4'b0000);
        lit(0, 1, 0);  instr(OP_B, 3'b011, 0, 0, 1'b0, 32'd0, 4'b0000);
        lit(0, 2, 0);  instr(OP_I, 3'b000, 9, 0, 1'b0, 32'd0, 4'b0000);      // timeout still traps
        lit(1, 0, 0);  instr(OP_I, 3'b000, 0, 0, 1'b0, 32'd0, 4'b0000);

        exp_valid = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
